// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder/subtractor.
package serial_adder_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter width: ceil(log2(w)), never below one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Purely combinational 1-bit full adder; the single arithmetic cell of the serial adder.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, LSB first, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to build the signed-overflow logic; otherwise overflow is tied to 0.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q;
    logic [WIDTH-1:0] a_sr_d, b_sr_d, sum_sr_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, sub_q;
    logic             busy_q, done_q, cout_q, ovf_q;
    logic [WIDTH-1:0] sum_q;
    logic             fa_b_s, fa_s_s, fa_c_s, ovf_d;

    fa_cell u_fa (
        .a_i (a_sr_q[0]),
        .b_i (fa_b_s),
        .c_i (carry_q),
        .s_o (fa_s_s),
        .c_o (fa_c_s)
    );

    // Next-state values for the shift registers and the overflow flag.
    always_comb begin
        fa_b_s   = b_sr_q[0] ^ sub_q;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = (sum_sr_q >> 1) | (WIDTH'(fa_s_s) << (WIDTH - 1));
`ifdef SERIAL_ADDER_OVF_EN
        // On the last bit carry_q is exactly the carry into the MSB.
        ovf_d    = carry_q ^ fa_c_s;
`else
        ovf_d    = 1'b0;
`endif
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        sub_q   <= sub;
                        carry_q <= sub ? 1'b1 : cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sr_q   <= a_sr_d;
                    b_sr_q   <= b_sr_d;
                    sum_sr_q <= sum_sr_d;
                    carry_q  <= fa_c_s;
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= sum_sr_d;
                        cout_q  <= fa_c_s;
                        ovf_q   <= ovf_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial, parametrised N-bit adder/subtractor built around a single full-adder cell reused once per clock. It accepts two WIDTH-bit operands on a start strobe, processes one bit per cycle LSB-first with a registered carry, and presents a registered sum, carry-out and signed-overflow flag with a one-cycle done pulse. It is the sequential successor to the combinational 1-bit full adder: one FA cell, any width, plus a subtract mode and a handshake.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..64.
- clk  input  1  single clock, all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request strobe; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in for add mode; captured on the accepting edge.
- sub  input  1  1 = A − B, 0 = A + B + cin; captured on the accepting edge.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; results valid.
- sum  output  WIDTH  result, held until the next accepted start.
- cout  output  1  final carry; in subtract mode 1 = no borrow.
- overflow  output  1  signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 → latch a, b, cin, sub into shift registers; bit counter ← 0; carry ← (sub ? 1 : cin); go RUN. start=0 → stay.
- RUN: FA cell adds a_sr[0], (sub ? ~b_sr[0] : b_sr[0]), carry; sum bit shifted into sum_sr at MSB; a_sr/b_sr shift right; carry ← FA carry-out; counter +1. On the cycle with counter = WIDTH−1: go DONE and load sum, cout and overflow outputs.
- DONE: done=1 for this cycle only. start=1 → accept new operands as from IDLE and go RUN; otherwise go IDLE.
- start in RUN is ignored; no queuing.
- In subtract mode cin is ignored.
- overflow = carry into MSB XOR carry out of MSB; the carry into the MSB is captured when counter = WIDTH−1.
- WIDTH=1: RUN lasts exactly one cycle; overflow = cin_to_bit0 XOR cout.
- Counter width: $clog2(WIDTH), minimum 1 bit; it never wraps past WIDTH−1.

## Timing
- Reset (rst_n=0 at an edge): state IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; internal shift registers and counter cleared.
- Reset during RUN or DONE aborts the operation; no done pulse; outputs are zero after the edge.
- Latency: start accepted at edge E0 → busy=1 from E0 through E(WIDTH) → outputs updated and done=1 after edge E(WIDTH) → done=0 after E(WIDTH+1).
- Throughput: one operation per WIDTH+1 cycles with start held high or re-asserted during DONE.
- sum, cout and overflow change only at the RUN→DONE edge or at reset; they are stable between done pulses.

## Configuration
- SERIAL_ADDER_OVF_EN defined: the overflow logic and the MSB-carry capture register are built; overflow behaves as specified.
- SERIAL_ADDER_OVF_EN undefined: no overflow logic; the overflow port remains and is tied to 0.

## Structure
- Package serial_adder_pkg: state enum type (IDLE, RUN, DONE); the WIDTH range limits as constants.
- Sub-module fa_cell: purely combinational 1-bit full adder (inputs a, b, carry-in; outputs sum, carry-out), instantiated once.
- The top level holds the FSM, counter, operand and sum shift registers, and the output registers.

## Test plan
- WIDTH=8, add, a=0x5A, b=0x33, cin=0 → after 8 busy cycles, done pulse with sum=0x8D, cout=0, overflow=1.
- Add, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0; repeat with cin=1 → sum=0x01, cout=1.
- Subtract, a=0x10, b=0x20 → sum=0xF0, cout=0, overflow=0. Subtract, a=0x80, b=0x01 → sum=0x7F, cout=1, overflow=1.
- Start pulses at cycles 2 and 4 of RUN → ignored, result unaffected. Start held high throughout → back-to-back done pulses every 9 cycles.
- rst_n=0 on the 4th RUN cycle → next edge: busy=0, sum=0, no done pulse; a fresh start then completes correctly.
- Rebuild without SERIAL_ADDER_OVF_EN → overflow=0 for the 0x5A+0x33 case; repeat the add cases at WIDTH=1 and WIDTH=16 (0xFFFF+0x0001 → 0x0000, cout=1).
